regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 15 +
 rtl/regwr_slot.sv | 56 +++++
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write arbiter.
//   DATA_W   - write data width
//   ADDR_W   - register index width
//   ZERO_REG - register index that is never written
//   grant_t  - arbiter channel identifier (A = ALU writeback, B = load writeback)
package regfile_pkg;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned ZERO_REG = 31;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;
endpackage

// File: rtl/regwr_slot.sv
// regwr_slot: one-entry holding register for a writeback requester.
// Writes that target ZERO_REG complete the handshake but are never stored.
// Ports:
//   Clk, Reset        - clock, synchronous active-high reset
//   i_valid           - requester has a write
//   i_rw, i_bus       - destination register and data
//   i_clear           - entry has been granted; empty the slot
//   o_ready           - slot can accept (registered Full and Reset only)
//   o_full            - slot holds an entry
//   o_rw, o_bus       - held destination register and data
module regwr_slot #(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_rw,
  input  logic [DATA_W-1:0] i_bus,
  input  logic              i_clear,
  output logic              o_ready,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_rw,
  output logic [DATA_W-1:0] o_bus
);
  import regfile_pkg::*;

  logic              r_full;
  logic [ADDR_W-1:0] r_rw;
  logic [DATA_W-1:0] r_bus;
  logic              w_load;

  always_comb begin
    o_ready = ~r_full & ~Reset;
    w_load  = i_valid & o_ready & (i_rw != ADDR_W'(ZERO_REG));
  end

  // A load only happens when empty and a clear only when full, so the two
  // never compete for the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_full <= 1'b0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_rw   <= i_rw;
      r_bus  <= i_bus;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_rw   = r_rw;
  assign o_bus  = r_bus;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between an ALU
// writeback requester (A) and a load writeback requester (B). Each has a
// one-entry slot; a round-robin arbiter drains slots into a registered
// output stage (RegWr/RW/BusW) committed by the register file on negedge.
// Ports:
//   Clk, Reset                 - clock, synchronous active-high reset
//   AValid/ARw/ABus, AReady    - requester A handshake
//   BValid/BRw/BBus, BReady    - requester B handshake
//   RegWr, RW, BusW            - register-file write port
//   PendMask                   - bit i set while a write to register i is held
// Optional build macro REGWR_FWD_EN adds LookupRa, FwdHit, FwdData
// (combinational forwarding lookup of pending writes).
module regfile_write_arbiter #(
  parameter int unsigned DATA_W   = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W   = regfile_pkg::ADDR_W,
  parameter int unsigned ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              AValid,
  input  logic [ADDR_W-1:0] ARw,
  input  logic [DATA_W-1:0] ABus,
  output logic              AReady,
  input  logic              BValid,
  input  logic [ADDR_W-1:0] BRw,
  input  logic [DATA_W-1:0] BBus,
  output logic              BReady,
`ifdef REGWR_FWD_EN
  input  logic [ADDR_W-1:0] LookupRa,
  output logic              FwdHit,
  output logic [DATA_W-1:0] FwdData,
`endif
  output logic              RegWr,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic [31:0]       PendMask
);
  import regfile_pkg::*;

  logic              w_a_full, w_b_full;
  logic [ADDR_W-1:0] w_a_rw, w_b_rw;
  logic [DATA_W-1:0] w_a_bus, w_b_bus;
  logic              w_gnt_vld;
  grant_t            w_gnt;
  logic              w_a_clr, w_b_clr;

  grant_t            r_last_gnt;
  logic              r_regwr;
  logic [ADDR_W-1:0] r_rw;
  logic [DATA_W-1:0] r_busw;

  regwr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_slot_a (
    .Clk(Clk), .Reset(Reset), .i_valid(AValid), .i_rw(ARw), .i_bus(ABus),
    .i_clear(w_a_clr), .o_ready(AReady), .o_full(w_a_full),
    .o_rw(w_a_rw), .o_bus(w_a_bus)
  );

  regwr_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_slot_b (
    .Clk(Clk), .Reset(Reset), .i_valid(BValid), .i_rw(BRw), .i_bus(BBus),
    .i_clear(w_b_clr), .o_ready(BReady), .o_full(w_b_full),
    .o_rw(w_b_rw), .o_bus(w_b_bus)
  );

  always_comb begin
    w_gnt_vld = w_a_full | w_b_full;
    if (w_a_full && w_b_full)
      w_gnt = (r_last_gnt == GNT_A) ? GNT_B : GNT_A;
    else if (w_a_full)
      w_gnt = GNT_A;
    else
      w_gnt = GNT_B;
    w_a_clr = w_gnt_vld & (w_gnt == GNT_A);
    w_b_clr = w_gnt_vld & (w_gnt == GNT_B);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_regwr    <= 1'b0;
      r_rw       <= '0;
      r_busw     <= '0;
      r_last_gnt <= GNT_B;
    end else if (w_gnt_vld) begin
      r_regwr    <= 1'b1;
      r_rw       <= (w_gnt == GNT_A) ? w_a_rw  : w_b_rw;
      r_busw     <= (w_gnt == GNT_A) ? w_a_bus : w_b_bus;
      r_last_gnt <= w_gnt;
    end else begin
      r_regwr    <= 1'b0;
    end
  end

  assign RegWr = r_regwr;
  assign RW    = r_rw;
  assign BusW  = r_busw;

  // ZERO_REG never enters a slot or the output stage, so bit 31 stays clear.
  always_comb begin
    PendMask = (32'(w_a_full) << w_a_rw)
             | (32'(w_b_full) << w_b_rw)
             | (32'(r_regwr)  << r_rw);
  end

`ifdef REGWR_FWD_EN
  grant_t r_newest;
  logic   w_a_load, w_b_load;
  logic   w_new_hit, w_old_hit;

  always_comb begin
    w_a_load = AValid & AReady & (ARw != ADDR_W'(ZERO_REG));
    w_b_load = BValid & BReady & (BRw != ADDR_W'(ZERO_REG));
  end

  // Simultaneous loads only occur with both slots empty (no grant that edge);
  // the later-granted entry is then the one matching LastGnt.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_newest <= GNT_B;
    else if (w_a_load && w_b_load)
      r_newest <= r_last_gnt;
    else if (w_a_load)
      r_newest <= GNT_A;
    else if (w_b_load)
      r_newest <= GNT_B;
  end

  always_comb begin
    FwdHit    = 1'b0;
    FwdData   = '0;
    w_new_hit = (r_newest == GNT_A) ? (w_a_full && w_a_rw == LookupRa)
                                    : (w_b_full && w_b_rw == LookupRa);
    w_old_hit = (r_newest == GNT_A) ? (w_b_full && w_b_rw == LookupRa)
                                    : (w_a_full && w_a_rw == LookupRa);
    if (LookupRa != ADDR_W'(ZERO_REG)) begin
      if (r_regwr && r_rw == LookupRa) begin
        FwdHit  = 1'b1;
        FwdData = r_busw;
      end else if (w_new_hit) begin
        FwdHit  = 1'b1;
        FwdData = (r_newest == GNT_A) ? w_a_bus : w_b_bus;
      end else if (w_old_hit) begin
        FwdHit  = 1'b1;
        FwdData = (r_newest == GNT_A) ? w_b_bus : w_a_bus;
      end
    end
  end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  logic        Clk;
  logic        Reset;
  logic        AValid, BValid;
  logic [4:0]  ARw, BRw;
  logic [63:0] ABus, BBus;
  logic        AReady, BReady;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic [31:0] PendMask;
`ifdef REGWR_FWD_EN
  logic [4:0]  LookupRa;
  logic        FwdHit;
  logic [63:0] FwdData;
`endif

  int n_chk;
  int n_fail;
  logic [63:0] rf [32];

  regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .Clk(Clk), .Reset(Reset),
    .AValid(AValid), .ARw(ARw), .ABus(ABus), .AReady(AReady),
    .BValid(BValid), .BRw(BRw), .BBus(BBus), .BReady(BReady),
`ifdef REGWR_FWD_EN
    .LookupRa(LookupRa), .FwdHit(FwdHit), .FwdData(FwdData),
`endif
    .RegWr(RegWr), .RW(RW), .BusW(BusW), .PendMask(PendMask)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register-file model: commits on negedge, as the real register file does.
  always @(negedge Clk) if (RegWr) rf[RW] <= BusW;

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int ia, ib, k;
    logic ra, rb;
    logic [63:0] exp_rw, exp_bus;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    Reset = 1'b1;
    AValid = 1'b1; ARw = 5'd3; ABus = 64'h1;
    BValid = 1'b0; BRw = '0;   BBus = '0;
`ifdef REGWR_FWD_EN
    LookupRa = 5'd0;
`endif

    // Reset held two cycles with AValid high
    tick; tick;
    chk("rst_aready", 64'(AReady), 64'd0);
    chk("rst_bready", 64'(BReady), 64'd0);
    chk("rst_regwr", 64'(RegWr), 64'd0);
    chk("rst_rw", 64'(RW), 64'd0);
    chk("rst_busw", BusW, 64'd0);
    chk("rst_pend", 64'(PendMask), 64'd0);

    // A and B on the same edge after reset: A wins the tie
    Reset = 1'b0;
    AValid = 1'b1; ARw = 5'd1; ABus = 64'h100;
    BValid = 1'b1; BRw = 5'd2; BBus = 64'h200;
    #1;
    chk("post_rst_aready", 64'(AReady), 64'd1);
    tick;
    AValid = 1'b0; BValid = 1'b0;
    chk("ab_pend_acc", 64'(PendMask), 64'h6);
    chk("ab_regwr_acc", 64'(RegWr), 64'd0);
    tick;
    chk("ab_first_rw", 64'(RW), 64'd1);
    chk("ab_first_bus", BusW, 64'h100);
    chk("ab_first_pend", 64'(PendMask), 64'h6);
    tick;
    chk("ab_second_we", 64'(RegWr), 64'd1);
    chk("ab_second_rw", 64'(RW), 64'd2);
    chk("ab_second_bus", BusW, 64'h200);
    chk("ab_second_pend", 64'(PendMask), 64'h4);
    tick;
    chk("ab_idle_we", 64'(RegWr), 64'd0);

    // Sustained traffic on both channels: A,B,A,B at one write per cycle
    ia = 0; ib = 0;
    AValid = 1'b1; ARw = 5'd10; ABus = 64'hA0;
    BValid = 1'b1; BRw = 5'd20; BBus = 64'hB0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      ra = AReady; rb = BReady;
      tick;
      if (ra) begin ia++; ARw = 5'(10 + ia); ABus = 64'hA0 + 64'(ia); end
      if (rb) begin ib++; BRw = 5'(20 + ib); BBus = 64'hB0 + 64'(ib); end
      if (cyc >= 1) begin
        k = cyc - 1;
        exp_rw  = (k % 2 == 0) ? 64'(10 + k / 2) : 64'(20 + k / 2);
        exp_bus = (k % 2 == 0) ? 64'hA0 + 64'(k / 2) : 64'hB0 + 64'(k / 2);
        chk("rr_we", 64'(RegWr), 64'd1);
        chk("rr_rw", 64'(RW), exp_rw);
        chk("rr_bus", BusW, exp_bus);
      end
    end
    AValid = 1'b0; BValid = 1'b0;
    tick; tick; tick;
    chk("rr_drain_we", 64'(RegWr), 64'd0);
    chk("rr_drain_pend", 64'(PendMask), 64'd0);

    // A only: latency and pending mask window
    AValid = 1'b1; ARw = 5'd5; ABus = 64'hDEAD;
    tick;
    AValid = 1'b0;
    chk("a_pend_k", 64'(PendMask), 64'h20);
    chk("a_we_k", 64'(RegWr), 64'd0);
    chk("a_ready_k", 64'(AReady), 64'd0);
    tick;
    chk("a_we_k1", 64'(RegWr), 64'd1);
    chk("a_rw_k1", 64'(RW), 64'd5);
    chk("a_bus_k1", BusW, 64'hDEAD);
    chk("a_pend_k1", 64'(PendMask), 64'h20);
    chk("a_ready_k1", 64'(AReady), 64'd1);
    tick;
    chk("a_we_k2", 64'(RegWr), 64'd0);
    chk("a_pend_k2", 64'(PendMask), 64'd0);
    chk("a_rw_hold", 64'(RW), 64'd5);
    chk("a_bus_hold", BusW, 64'hDEAD);
    chk("rf5", rf[5], 64'hDEAD);

    // Zero-register write: accepted and dropped
    AValid = 1'b1; ARw = 5'd31; ABus = 64'hFFFF;
    tick;
    AValid = 1'b0;
    chk("z_ready", 64'(AReady), 64'd1);
    chk("z_pend", 64'(PendMask), 64'd0);
    tick;
    chk("z_we1", 64'(RegWr), 64'd0);
    tick;
    chk("z_we2", 64'(RegWr), 64'd0);
    chk("z_pend2", 64'(PendMask), 64'd0);

    // B-only write leaves LastGnt=B
    BValid = 1'b1; BRw = 5'd3; BBus = 64'h33;
    tick;
    BValid = 1'b0;
    tick;
    chk("b_rw", 64'(RW), 64'd3);
    chk("b_bus", BusW, 64'h33);
    tick;

    // Same destination from both channels: A first, B last in register file
    AValid = 1'b1; ARw = 5'd7; ABus = 64'h11;
    BValid = 1'b1; BRw = 5'd7; BBus = 64'h22;
    tick;
    AValid = 1'b0; BValid = 1'b0;
    chk("s7_pend", 64'(PendMask), 64'h80);
`ifdef REGWR_FWD_EN
    LookupRa = 5'd7;  #1;
    chk("fwd7_hit", 64'(FwdHit), 64'd1);
    chk("fwd7_data", FwdData, 64'h22);
    LookupRa = 5'd9;  #1;
    chk("fwd9_hit", 64'(FwdHit), 64'd0);
    LookupRa = 5'd31; #1;
    chk("fwd31_hit", 64'(FwdHit), 64'd0);
`endif
    tick;
    chk("s7_first_bus", BusW, 64'h11);
    tick;
    chk("s7_second_bus", BusW, 64'h22);
    tick;
    chk("rf7", rf[7], 64'h22);

    // Reset while both slots are full
    AValid = 1'b1; ARw = 5'd8; ABus = 64'h88;
    BValid = 1'b1; BRw = 5'd9; BBus = 64'h99;
    tick;
    AValid = 1'b0; BValid = 1'b0;
    chk("mr_pend_full", 64'(PendMask), 64'h300);
    Reset = 1'b1;
    tick;
    chk("mr_we", 64'(RegWr), 64'd0);
    chk("mr_pend", 64'(PendMask), 64'd0);
    chk("mr_aready", 64'(AReady), 64'd0);
    Reset = 1'b0;
    tick;
    chk("mr_we2", 64'(RegWr), 64'd0);
    chk("mr_pend2", 64'(PendMask), 64'd0);
    tick;
    chk("mr_rf8", rf[8], 64'd0);
    chk("mr_rf9", rf[9], 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
